multicycle_controller: RTL and testbench

- Moore-FSM control unit for the multicycle RISC-V datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives `ALUControl` with the ALU's 3-bit encoding: 000 add, 001 sub, 010 and, 011 or.
- Sits between the instruction register (op/funct fields) and the datapath muxes, register file, memory and ALU.

---
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle RISC-V datapath.
// Optional MC_BNE_EN adds bne support in the branch state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BRCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_out_state;
  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_take;
  logic       w_we_pc;
  logic       w_we_ir;
  logic       w_we_mem;
  logic       w_we_reg;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BRCH:      w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_JAL:     w_next = S_ALUWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Reset shows FETCH decode with all write enables masked
  assign w_out_state = rst ? S_FETCH : r_state;

  // Moore outputs
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_we_ir     = 1'b0;
    w_we_mem    = 1'b0;
    w_we_reg    = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = 2'b00;
    case (w_out_state)
      S_FETCH: begin
        w_we_ir     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_we_reg  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        w_we_mem = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB: w_we_reg = 1'b1;
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_BNE_EN
  always_comb begin
    case (funct3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = ~Zero;
      default: w_take = 1'b0;
    endcase
  end
`else
  assign w_take = Zero;
`endif

  assign w_we_pc  = w_pc_update | (w_branch & w_take);
  assign PCWrite  = w_we_pc  & ~rst;
  assign IRWrite  = w_we_ir  & ~rst;
  assign MemWrite = w_we_mem & ~rst;
  assign RegWrite = w_we_reg & ~rst;
  assign State    = r_state;

  // ALU decode
  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b111:  ALUControl = 3'b010;
          3'b110:  ALUControl = 3'b011;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate select depends only on the opcode
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BRCH: ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let inputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    tick(); tick(); tick(); #1;
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_pcw", 8'(PCWrite), 8'd0);
    chk("rst_irw", 8'(IRWrite), 8'd0);
    chk("rst_memw", 8'(MemWrite), 8'd0);
    chk("rst_regw", 8'(RegWrite), 8'd0);
    chk("rst_srcb", 8'(ALUSrcB), 8'd2);

    // lw
    rst = 1'b0; op = 7'b0000011; #1;
    chk("f_state", 8'(State), 8'd0);
    chk("f_irw", 8'(IRWrite), 8'd1);
    chk("f_pcw", 8'(PCWrite), 8'd1);
    chk("f_srcb", 8'(ALUSrcB), 8'd2);
    chk("f_ressrc", 8'(ResultSrc), 8'd2);
    tick();
    chk("lw_s1", 8'(State), 8'd1);
    chk("dec_srca", 8'(ALUSrcA), 8'd1);
    chk("dec_srcb", 8'(ALUSrcB), 8'd1);
    tick();
    chk("lw_s2", 8'(State), 8'd2);
    chk("madr_srca", 8'(ALUSrcA), 8'd2);
    tick();
    chk("lw_s3", 8'(State), 8'd3);
    chk("lw_adrsrc", 8'(AdrSrc), 8'd1);
    chk("lw_regw3", 8'(RegWrite), 8'd0);
    tick();
    chk("lw_s4", 8'(State), 8'd4);
    chk("lw_regw", 8'(RegWrite), 8'd1);
    chk("lw_ressrc", 8'(ResultSrc), 8'd1);
    chk("lw_imm", 8'(ImmSrc), 8'd0);
    tick();
    chk("lw_s0", 8'(State), 8'd0);

    // R-type
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    chk("r_s6", 8'(State), 8'd6);
    chk("r_sub", 8'(ALUControl), 8'd1);
    funct7b5 = 1'b0; #1;
    chk("r_add", 8'(ALUControl), 8'd0);
    funct3 = 3'b111; #1;
    chk("r_and", 8'(ALUControl), 8'd2);
    funct3 = 3'b110; #1;
    chk("r_or", 8'(ALUControl), 8'd3);
    funct3 = 3'b010; #1;
    chk("r_other", 8'(ALUControl), 8'd0);
    tick();
    chk("r_s7", 8'(State), 8'd7);
    chk("r_regw", 8'(RegWrite), 8'd1);
    tick();
    chk("r_s0", 8'(State), 8'd0);

    // I-type: funct7b5 must not turn addi into sub
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    chk("i_s8", 8'(State), 8'd8);
    chk("i_add", 8'(ALUControl), 8'd0);
    chk("i_srcb", 8'(ALUSrcB), 8'd1);
    tick();
    chk("i_s7", 8'(State), 8'd7);
    tick();

    // jal
    op = 7'b1101111; funct7b5 = 1'b0;
    tick();
    chk("jal_imm", 8'(ImmSrc), 8'd3);
    tick();
    chk("jal_s9", 8'(State), 8'd9);
    chk("jal_pcw", 8'(PCWrite), 8'd1);
    chk("jal_srca", 8'(ALUSrcA), 8'd1);
    chk("jal_srcb", 8'(ALUSrcB), 8'd2);
    tick();
    chk("jal_s7", 8'(State), 8'd7);
    tick();

    // beq / bne
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
    tick();
    chk("beq_imm", 8'(ImmSrc), 8'd2);
    tick();
    chk("beq_s10", 8'(State), 8'd10);
    chk("beq_pcw_z1", 8'(PCWrite), 8'd1);
    chk("beq_alu", 8'(ALUControl), 8'd1);
    Zero = 1'b0; #1;
    chk("beq_pcw_z0", 8'(PCWrite), 8'd0);
    funct3 = 3'b001; #1;
`ifdef MC_BNE_EN
    chk("bne_z0", 8'(PCWrite), 8'd1);
    Zero = 1'b1; #1;
    chk("bne_z1", 8'(PCWrite), 8'd0);
    funct3 = 3'b100; #1;
    chk("bxx_z1", 8'(PCWrite), 8'd0);
`else
    chk("bne_z0", 8'(PCWrite), 8'd0);
    Zero = 1'b1; #1;
    chk("bne_z1", 8'(PCWrite), 8'd1);
`endif
    tick();
    chk("beq_s0", 8'(State), 8'd0);
    Zero = 1'b0; funct3 = 3'b000;

    // Unknown opcode
    op = 7'b0000000;
    tick();
    chk("nop_s1", 8'(State), 8'd1);
    chk("nop_regw", 8'(RegWrite), 8'd0);
    chk("nop_memw", 8'(MemWrite), 8'd0);
    tick();
    chk("nop_s0", 8'(State), 8'd0);

    // sw interrupted by reset in MEMWRITE
    op = 7'b0100011;
    tick();
    chk("sw_imm", 8'(ImmSrc), 8'd1);
    tick();
    tick();
    chk("sw_s5", 8'(State), 8'd5);
    chk("sw_memw", 8'(MemWrite), 8'd1);
    rst = 1'b1; #1;
    chk("swrst_memw", 8'(MemWrite), 8'd0);
    chk("swrst_adr", 8'(AdrSrc), 8'd0);
    chk("swrst_pcw", 8'(PCWrite), 8'd0);
    tick();
    chk("swrst_s0", 8'(State), 8'd0);
    tick(); tick();
    chk("rst2_irw", 8'(IRWrite), 8'd0);
    rst = 1'b0; #1;
    chk("rel_irw", 8'(IRWrite), 8'd1);
    tick();
    chk("rel_s1", 8'(State), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
